// File: rtl/sm4_key_schedule_ctrl.sv
// SM4 key-schedule controller: runs the 32 key-expansion rounds on one round_key_expansion instance.
// Define SM4_KS_RKSTORE_EN to add a 32x32-bit round-key store read through rd_addr/rd_data.

module round_key_expansion (
    input  logic [127:0] data,
    input  logic [31:0]  cki,
    output logic [127:0] result
);
    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    logic [31:0] k0, k1, k2, k3;
    logic [31:0] t_in, sb, l_out;

    assign {k0, k1, k2, k3} = data;
    assign t_in  = k1 ^ k2 ^ k3 ^ cki;
    assign sb    = {SBOX[t_in[31:24]], SBOX[t_in[23:16]], SBOX[t_in[15:8]], SBOX[t_in[7:0]]};
    // Key-schedule linear transform: B ^ (B <<< 13) ^ (B <<< 23)
    assign l_out = sb ^ ((sb << 13) | (sb >> 19)) ^ ((sb << 23) | (sb >> 9));
    assign result = {k1, k2, k3, k0 ^ l_out};
endmodule

// state | meaning
// IDLE  | key_ready=1, waiting for a key handshake
// RUN   | one expansion round per cycle, cnt = round index
// DONE  | one-cycle wrap-up, raises keys_valid
module sm4_key_schedule_ctrl #(
    parameter int NROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [127:0] key,
    output logic         key_ready,
    input  logic         abort,
    output logic         busy,
    output logic         rk_valid,
    output logic [4:0]   rk_idx,
    output logic [31:0]  rk,
    output logic         keys_valid,
    input  logic [4:0]   rd_addr,
    output logic [31:0]  rd_data
);
    localparam logic [127:0] FK   = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
    localparam logic [4:0]   LAST = 5'(NROUNDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [4:0]    cnt;
    logic [127:0]  k_reg;
    logic [127:0]  round_out;
    logic [7:0]    ck_base;
    logic [31:0]   ck;

    // CK byte j of round i is ((4*i + j) * 7) mod 256; 8-bit arithmetic gives the mod for free
    assign ck_base = {1'b0, cnt, 2'b00};
    assign ck = {ck_base * 8'd7, (ck_base + 8'd1) * 8'd7, (ck_base + 8'd2) * 8'd7, (ck_base + 8'd3) * 8'd7};

    round_key_expansion u_round (
        .data   (k_reg),
        .cki    (ck),
        .result (round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            k_reg      <= '0;
            rk         <= '0;
            rk_idx     <= '0;
            rk_valid   <= 1'b0;
            keys_valid <= 1'b0;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            cnt        <= '0;
            rk_valid   <= 1'b0;
            keys_valid <= 1'b0;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rk_valid <= 1'b0;
                    if (key_valid && key_ready) begin
                        k_reg      <= key ^ FK;
                        cnt        <= '0;
                        keys_valid <= 1'b0;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    k_reg    <= round_out;
                    rk       <= round_out[31:0];
                    rk_idx   <= cnt;
                    rk_valid <= 1'b1;
                    if (cnt == LAST) state <= DONE;
                    else             cnt   <= cnt + 5'd1;
                end
                DONE: begin
                    rk_valid   <= 1'b0;
                    keys_valid <= 1'b1;
                    key_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SM4_KS_RKSTORE_EN
    logic [31:0] store [NROUNDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NROUNDS; i++) store[i] <= '0;
        end else if (!abort && state == RUN) begin
            store[cnt] <= round_out[31:0];
        end
    end

    assign rd_data = store[rd_addr];
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data = '0;
`endif
endmodule

// File: tb/tb_sm4_key_schedule_ctrl.sv
// Self-checking bench for sm4_key_schedule_ctrl: scoreboard of expected round keys from a
// word-oriented SM4 key-schedule model, compared as rk_valid strobes appear.
module tb_sm4_key_schedule_ctrl;
    localparam logic [7:0] SBOX_TB [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };
    localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] rk;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic [127:0] key = '0;
    logic         abort = 1'b0;
    logic [4:0]   rd_addr = '0;
    logic         key_ready, busy, rk_valid, keys_valid;
    logic [4:0]   rk_idx;
    logic [31:0]  rk, rd_data;

    int           n_assert = 0;
    int           n_fail = 0;
    int           strobes = 0;
    exp_t         exp_q[$];
    logic [31:0]  model_rk [32];
    logic [31:0]  cap_rk [32];

    always #5 clk = ~clk;

    sm4_key_schedule_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key        (key),
        .key_ready  (key_ready),
        .abort      (abort),
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_idx     (rk_idx),
        .rk         (rk),
        .keys_valid (keys_valid),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    function automatic logic [31:0] tb_ck(input int i);
        logic [31:0] c = '0;
        for (int j = 0; j < 4; j++) c = (c << 8) | 32'(((4 * i + j) * 7) % 256);
        return c;
    endfunction

    function automatic logic [31:0] tb_tprime(input logic [31:0] a);
        logic [31:0] b;
        b = {SBOX_TB[a[31:24]], SBOX_TB[a[23:16]], SBOX_TB[a[15:8]], SBOX_TB[a[7:0]]};
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    task automatic model_expand(input logic [127:0] mk);
        logic [31:0] kw [36];
        kw[0] = mk[127:96] ^ 32'hA3B1BAC6;
        kw[1] = mk[95:64]  ^ 32'h56AA3350;
        kw[2] = mk[63:32]  ^ 32'h677D9197;
        kw[3] = mk[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            kw[i + 4] = kw[i] ^ tb_tprime(kw[i + 1] ^ kw[i + 2] ^ kw[i + 3] ^ tb_ck(i));
            model_rk[i] = kw[i + 4];
        end
    endtask

    task automatic push_expected(input int count);
        exp_t e;
        for (int i = 0; i < count; i++) begin
            e.idx = 5'(i);
            e.rk  = model_rk[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rk_valid strobe must match the next expected (index, key) pair
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && rk_valid === 1'b1) begin
            strobes++;
            cap_rk[rk_idx] = rk;
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL stream_unexpected: got idx %0d rk %h, required no strobe", rk_idx, rk);
            end else begin
                e = exp_q.pop_front();
                if (rk_idx !== e.idx || rk !== e.rk) begin
                    n_fail++;
                    $display("FAIL stream_key: got idx %0d rk %h, required idx %0d rk %h", rk_idx, rk, e.idx, e.rk);
                end
            end
        end
    end

    task automatic run_key(input logic [127:0] k, output int cycles);
        key = k;
        key_valid = 1'b1;
        n_assert++;
        if (key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_ready: got key_ready %b, required 1", key_ready);
        end
        tick();
        key_valid = 1'b0;
        n_assert++;
        if (busy !== 1'b1 || key_ready !== 1'b0 || keys_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_state: got busy %b key_ready %b keys_valid %b, required 1 0 0", busy, key_ready, keys_valid);
        end
        cycles = 0;
        while (keys_valid !== 1'b1 && cycles < 60) begin
            tick();
            cycles++;
        end
        n_assert++;
        if (keys_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL keys_valid_timeout: got keys_valid %b after %0d cycles, required 1", keys_valid, cycles);
        end
    endtask

    task automatic test_reset();
        #12;
        n_assert++;
        if (key_ready !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0 || keys_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got ready %b busy %b rk_valid %b keys_valid %b, required 1 0 0 0", key_ready, busy, rk_valid, keys_valid);
        end
        n_assert++;
        if (rk !== 32'h0 || rk_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_rk: got rk %h idx %0d, required 0 0", rk, rk_idx);
        end
        n_assert++;
        if (rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rd_data: got %h, required 0", rd_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_standard_vector();
        int cyc;
        model_expand(STD_KEY);
        push_expected(32);
        strobes = 0;
        run_key(STD_KEY, cyc);
        n_assert++;
        if (cyc !== 33) begin
            n_fail++;
            $display("FAIL std_latency: got keys_valid %0d cycles after accept, required 33", cyc);
        end
        n_assert++;
        if (strobes !== 32 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL std_strobes: got %0d strobes, %0d pending, required 32 and 0", strobes, exp_q.size());
        end
        n_assert++;
        if (cap_rk[0] !== 32'hF12186F9 || cap_rk[31] !== 32'h9124A012) begin
            n_fail++;
            $display("FAIL std_vector: got rk0 %h rk31 %h, required F12186F9 9124A012", cap_rk[0], cap_rk[31]);
        end
        n_assert++;
        if (key_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL std_idle: got key_ready %b busy %b, required 1 0", key_ready, busy);
        end
    endtask

    task automatic test_rd_sweep();
`ifdef SM4_KS_RKSTORE_EN
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            #1;
            n_assert++;
            if (rd_data !== model_rk[i]) begin
                n_fail++;
                $display("FAIL rd_sweep: addr %0d got %h, required %h", i, rd_data, model_rk[i]);
            end
        end
        rd_addr = 5'd0;
        #1;
        n_assert++;
        if (rd_data !== 32'hF12186F9) begin
            n_fail++;
            $display("FAIL rd_addr0: got %h, required F12186F9", rd_data);
        end
        rd_addr = 5'd31;
        #1;
        n_assert++;
        if (rd_data !== 32'h9124A012) begin
            n_fail++;
            $display("FAIL rd_addr31: got %h, required 9124A012", rd_data);
        end
`else
        for (int i = 0; i < 32; i += 7) begin
            rd_addr = 5'(i);
            #1;
            n_assert++;
            if (rd_data !== 32'h0) begin
                n_fail++;
                $display("FAIL rd_tied_zero: addr %0d got %h, required 0", i, rd_data);
            end
        end
`endif
        rd_addr = 5'd0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] ka, kb;
        int cyc;
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        model_expand(ka);
        push_expected(32);
        model_expand(kb);
        push_expected(32);
        strobes = 0;
        key = ka;
        key_valid = 1'b1;
        tick();
        key = kb;
        cyc = 0;
        while (keys_valid !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        n_assert++;
        if (cyc !== 33 || strobes !== 32) begin
            n_fail++;
            $display("FAIL b2b_first: got %0d cycles %0d strobes, required 33 and 32", cyc, strobes);
        end
        n_assert++;
        if (key_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready: got key_ready %b busy %b, required 1 0", key_ready, busy);
        end
        tick();
        key_valid = 1'b0;
        n_assert++;
        if (keys_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got keys_valid %b busy %b, required 0 1", keys_valid, busy);
        end
        cyc = 0;
        while (keys_valid !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        n_assert++;
        if (cyc !== 33 || strobes !== 64 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_second: got %0d cycles %0d strobes %0d pending, required 33 64 0", cyc, strobes, exp_q.size());
        end
    endtask

    task automatic test_abort();
        logic [127:0] k;
        logic found;
        k = {$urandom, $urandom, $urandom, $urandom};
        model_expand(k);
        push_expected(11);
        strobes = 0;
        found = 1'b0;
        key = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            if (rk_valid === 1'b1 && rk_idx === 5'd10) found = 1'b1;
        end
        n_assert++;
        if (!found) begin
            n_fail++;
            $display("FAIL abort_reach_idx10: got no strobe with idx 10, required one");
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_assert++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || keys_valid !== 1'b0 || key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_clear: got rk_valid %b busy %b keys_valid %b ready %b, required 0 0 0 1", rk_valid, busy, keys_valid, key_ready);
        end
        repeat (5) tick();
        n_assert++;
        if (keys_valid !== 1'b0 || strobes !== 11 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL abort_after: got keys_valid %b strobes %0d pending %0d, required 0 11 0", keys_valid, strobes, exp_q.size());
        end
`ifdef SM4_KS_RKSTORE_EN
        rd_addr = 5'd5;
        #1;
        n_assert++;
        if (rd_data !== model_rk[5]) begin
            n_fail++;
            $display("FAIL abort_store_kept: got %h, required %h", rd_data, model_rk[5]);
        end
        rd_addr = 5'd0;
`endif
        key = {$urandom, $urandom, $urandom, $urandom};
        key_valid = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        key_valid = 1'b0;
        n_assert++;
        if (busy !== 1'b0 || key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_priority: got busy %b key_ready %b, required 0 1", busy, key_ready);
        end
        repeat (3) tick();
        n_assert++;
        if (strobes !== 11 || keys_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_accept: got strobes %0d keys_valid %b, required 11 0", strobes, keys_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        model_expand(STD_KEY);
        push_expected(32);
        key = STD_KEY;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (6) tick();
        #3;
        rst = 1'b1;
        #1;
        n_assert++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1 || keys_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_flags: got rk_valid %b busy %b ready %b keys_valid %b, required 0 0 1 0", rk_valid, busy, key_ready, keys_valid);
        end
        n_assert++;
        if (rk !== 32'h0 || rk_idx !== 5'd0 || rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_data: got rk %h idx %0d rd_data %h, required 0 0 0", rk, rk_idx, rd_data);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        push_expected(32);
        strobes = 0;
        run_key(STD_KEY, cyc);
        n_assert++;
        if (cyc !== 33 || strobes !== 32 || cap_rk[0] !== 32'hF12186F9) begin
            n_fail++;
            $display("FAIL rst_mid_rerun: got %0d cycles %0d strobes rk0 %h, required 33 32 F12186F9", cyc, strobes, cap_rk[0]);
        end
    endtask

    task automatic test_ck_probe();
        logic [31:0] ck_exp;
        model_expand(128'h0);
        push_expected(32);
        strobes = 0;
        key = 128'h0;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            ck_exp = tb_ck(int'(dut.cnt));
            n_assert++;
            if (dut.ck !== ck_exp || dut.cnt !== 5'(c)) begin
                n_fail++;
                $display("FAIL ck_probe: cycle %0d got cnt %0d ck %h, required cnt %0d ck %h", c, dut.cnt, dut.ck, c, ck_exp);
            end
            if (c == 0 || c == 1 || c == 31) begin
                ck_exp = (c == 0) ? 32'h00070E15 : (c == 1) ? 32'h1C232A31 : 32'h646B7279;
                n_assert++;
                if (dut.ck !== ck_exp) begin
                    n_fail++;
                    $display("FAIL ck_known: round %0d got %h, required %h", c, dut.ck, ck_exp);
                end
            end
            @(posedge clk);
            #1;
        end
        tick();
        n_assert++;
        if (keys_valid !== 1'b1 || strobes !== 32 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL zero_key_stream: got keys_valid %b strobes %0d pending %0d, required 1 32 0", keys_valid, strobes, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_standard_vector();
        test_rd_sweep();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        test_ck_probe();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sm4_key_schedule_ctrl.md
Name: sm4_key_schedule_ctrl

Overview:
Sequential controller that drives one instance of the existing combinational SM4 key-expansion round (`round_key_expansion`) for 32 consecutive cycles. It generates all 32 SM4 round keys from a 128-bit user key.
- Accepts a key via valid/ready handshake.
- Applies the FK whitening and generates the CK constants on the fly.
- Streams each round key out as it is produced and optionally stores all 32 for random-access reads.
- Sits between the key-load interface and the SM4 round datapath; the encrypt/decrypt engine reads keys forward or reverse by index.

Parameters:
- NROUNDS, 32, number of key-expansion rounds. Fixed at 32 for SM4; other values are unsupported.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- key_valid, input, 1, user key presented.
- key, input, 128, user key MK0..MK3; MK0 = key[127:96].
- key_ready, output, 1, controller can accept a key.
- abort, input, 1, synchronous clear of any operation.
- busy, output, 1, expansion in progress.
- rk_valid, output, 1, one-cycle strobe: rk/rk_idx carry a new round key.
- rk_idx, output, 5, index of rk (0..31).
- rk, output, 32, round key rk[rk_idx].
- keys_valid, output, 1, all 32 keys produced for the current key.
- rd_addr, input, 5, round-key read address.
- rd_data, output, 32, stored round key at rd_addr (combinational read).

Behaviour:
- Reset values: all outputs 0 except key_ready=1; FSM=IDLE; round counter cnt=0; working state K=0; key store cleared to 0.
- FSM states and transitions:
  - IDLE: key_ready=1, busy=0. On key_valid&key_ready at edge E0: K <= key ^ {A3B1BAC6,56AA3350,677D9197,B27022DC}, cnt <= 0, keys_valid <= 0, go to RUN.
  - RUN: key_ready=0, busy=1. Each cycle, the round block receives data=K and cki=CK(cnt). At the edge:
    - K <= result; rk <= result[31:0]; rk_idx <= cnt; rk_valid <= 1; store[cnt] <= result[31:0]; cnt <= cnt+1.
    - When cnt==31: go to DONE instead of incrementing.
  - DONE: one cycle; keys_valid <= 1, rk_valid <= 0, go to IDLE.
- Timing:
  - rk_valid is high for exactly 32 consecutive cycles, following edges E1..E32.
  - keys_valid rises after edge E33.
  - key_ready returns to 1 in the cycle after E33.
- CK generation: byte j (j=0 MSB) of CK(i) = ((4*i+j)*7) mod 256, computed combinationally from cnt with no ROM. Checks: CK(0)=00070E15, CK(1)=1C232A31, CK(31)=646B7279.
- keys_valid stays 1 in IDLE until a new key handshake or abort; it drops at the accepting edge.
- key_valid during RUN/DONE is ignored (key_ready=0); the key is not latched.
- abort (any state) at the next edge:
  - FSM=IDLE, cnt=0, rk_valid=0, keys_valid=0.
  - Store contents are retained but treated as invalid.
  - abort has priority over a simultaneous key handshake; the key is not accepted.
- Mid-operation rst clears everything asynchronously; no partial keys are reported.
- Keys are never skipped or repeated; rk_idx increments by exactly 1 per rk_valid strobe.

Optional Feature:
- Macro: SM4_KS_RKSTORE_EN.
- Defined: 32x32-bit register store present; rd_data = store[rd_addr].
- Undefined: no store; rd_data tied to 0; rk stream and all other behaviour unchanged.

Test Plan:
- Reset, then key=0123456789ABCDEFFEDCBA9876543210 with key_valid=1 → handshake in 1 cycle; 32 rk_valid strobes; rk_idx 0 carries F12186F9, rk_idx 31 carries 9124A012; keys_valid=1 after E33.
- With SM4_KS_RKSTORE_EN, after the above, sweep rd_addr 0..31 → rd_data matches the streamed rk values; rd_addr=0 → F12186F9, rd_addr=31 → 9124A012.
- Second key presented while busy (held key_valid=1) → ignored until key_ready=1, then accepted; stream restarts at rk_idx 0 and keys_valid drops at the accept edge.
- abort asserted after rk_idx=10 → rk_valid=0 and busy=0 next cycle, keys_valid stays 0; abort with a simultaneous key_valid in IDLE → key not accepted.
- rst asserted mid-RUN (async, between edges) → all outputs immediately at reset values and key_ready=1; a fresh key then yields correct F12186F9 first key.
- All-zero key → 32 strobes, no X on rk, rk_idx sequence 0..31 exactly once; check CK(cnt) against the formula each cycle via a probe.
